keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row synchronizer, per-column dwell,
// debounced press/release with a one-cycle key_valid pulse per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam int            CW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam bit            SINGLE   = (DEBOUNCE_CNT == 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Row index selects the keypad line, column index the position within it.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  state_t        state_r, state_s;
  logic [3:0]    sync_r, rs_r;
  logic [DW-1:0] div_r;
  logic [3:0]    col_r, col_s, col_next_s;
  logic [1:0]    cand_r, cand_s, low_s;
  logic [CW-1:0] match_r, match_s, match_inc_s;
  logic [CW-1:0] rel_r, rel_s, rel_inc_s;
  logic [3:0]    key_code_r, key_code_s;
  logic          key_valid_r, key_valid_s;
  logic          key_held_r, key_held_s;
  logic          tick_s, any_low_s;

  assign tick_s      = (div_r == DIV_LAST);
  assign any_low_s   = (rs_r != 4'hF);
  assign low_s       = lowest_low(rs_r);
  assign col_next_s  = {col_r[2:0], col_r[3]};
  assign match_inc_s = match_r + CNT_ONE;
  assign rel_inc_s   = rel_r + CNT_ONE;

  // Two-flop row synchronizer (idles high) and column dwell counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 4'hF;
      rs_r   <= 4'hF;
      div_r  <= {DW{1'b0}};
    end else begin
      sync_r <= row;
      rs_r   <= sync_r;
      div_r  <= tick_s ? {DW{1'b0}} : div_r + DW'(1);
    end
  end

  // Scan/debounce decisions, evaluated only on sample ticks
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    cand_s      = cand_r;
    match_s     = match_r;
    rel_s       = rel_r;
    key_code_s  = key_code_r;
    key_valid_s = 1'b0;
    key_held_s  = key_held_r;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (any_low_s) begin
            cand_s  = low_s;
            match_s = CNT_ONE;
            if (SINGLE) begin
              state_s     = ST_HELD;
              match_s     = CNT_ZERO;
              key_code_s  = key_map(col_index(col_r), low_s);
              key_valid_s = 1'b1;
              key_held_s  = 1'b1;
            end else begin
              state_s = ST_DEBOUNCE;
            end
          end else begin
            col_s = col_next_s;
          end
        end
        ST_DEBOUNCE: begin
          if (any_low_s && (low_s == cand_r)) begin
            match_s = match_inc_s;
            if (match_inc_s == CNT_DONE) begin
              state_s     = ST_HELD;
              match_s     = CNT_ZERO;
              key_code_s  = key_map(col_index(col_r), cand_r);
              key_valid_s = 1'b1;
              key_held_s  = 1'b1;
            end else begin
              state_s = ST_DEBOUNCE;
            end
          end else begin
            state_s = ST_SCAN;
            match_s = CNT_ZERO;
            col_s   = col_next_s;
          end
        end
        ST_HELD: begin
          // Column stays frozen, so keys in other columns are invisible here.
          if (!any_low_s) begin
            rel_s = CNT_ONE;
            if (SINGLE) begin
              state_s    = ST_SCAN;
              rel_s      = CNT_ZERO;
              key_held_s = 1'b0;
              col_s      = col_next_s;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            state_s = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (!any_low_s) begin
            rel_s = rel_inc_s;
            if (rel_inc_s == CNT_DONE) begin
              state_s    = ST_SCAN;
              rel_s      = CNT_ZERO;
              key_held_s = 1'b0;
              col_s      = col_next_s;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            state_s = ST_HELD;
            rel_s   = CNT_ZERO;
          end
        end
        default: begin
          state_s = ST_SCAN;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_SCAN;
      col_r       <= 4'b1110;
      cand_r      <= 2'd0;
      match_r     <= CNT_ZERO;
      rel_r       <= CNT_ZERO;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      cand_r      <= cand_s;
      match_r     <= match_s;
      rel_r       <= rel_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      key_held_r  <= key_held_s;
    end
  end

  assign col       = col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated keypad matrix with bounce, checked every
// cycle against a tick-level behavioural model of the scanner.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  // Indexed row*4 + col.
  localparam logic [3:0] KEY_LUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  bit          bounce_open;
  int          n_checks;
  int          n_pass;
  int          pulse_cnt;

  // Model state, all at sample-tick granularity.
  int          m_edges;
  int          m_col;
  int          m_streak;
  int          m_cand;
  int          m_quiet;
  bit          m_locked;
  bit          m_valid;
  logic [3:0]  m_code;
  logic [3:0]  m_d1, m_d2;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] pad_rows(input logic [15:0] p, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int ci = 0; ci < 4; ci++)
      if (!c[ci])
        for (int ri = 0; ri < 4; ri++)
          if (p[ri*4+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] exp_col();
    logic [3:0] c;
    c = 4'hF;
    c[m_col] = 1'b0;
    return c;
  endfunction

  task automatic model_reset();
    m_edges = 0; m_col = 0; m_streak = 0; m_cand = 0; m_quiet = 0;
    m_locked = 1'b0; m_valid = 1'b0; m_code = 4'h0; m_d1 = 4'hF; m_d2 = 4'hF;
  endtask

  task automatic model_tick(input logic [3:0] s);
    bit hit;
    int lr;
    hit = (s != 4'hF);
    lr = 0;
    for (int r = 3; r >= 0; r--) if (!s[r]) lr = r;
    if (!m_locked) begin
      if (hit && (m_streak == 0 || lr == m_cand)) begin
        if (m_streak == 0) m_cand = lr;
        m_streak++;
        if (m_streak == DEBOUNCE_CNT) begin
          m_code = KEY_LUT[m_cand*4 + m_col];
          m_valid = 1'b1; m_locked = 1'b1; m_streak = 0; m_quiet = 0;
        end
      end else begin
        m_streak = 0;
        m_col = (m_col + 1) % 4;
      end
    end else if (!hit) begin
      m_quiet++;
      if (m_quiet == DEBOUNCE_CNT) begin
        m_locked = 1'b0; m_quiet = 0;
        m_col = (m_col + 1) % 4;
      end
    end else begin
      m_quiet = 0;
    end
  endtask

  // Decisions at clock edge e see the row value present at edge e-2.
  task automatic model_edge(input logic [3:0] r_now);
    logic [3:0] smp;
    smp = m_d2;
    m_d2 = m_d1;
    m_d1 = r_now;
    m_edges++;
    m_valid = 1'b0;
    if (m_edges % SCAN_DIV == 0) model_tick(smp);
  endtask

  task automatic step();
    row = bounce_open ? 4'hF : pad_rows(pressed, col);
    @(posedge clk);
    model_edge(row);
    @(negedge clk);
    if (key_valid === 1'b1) pulse_cnt++;
    check_val("col", 32'(col), 32'(exp_col()));
    check_val("key_valid", 32'(key_valid), 32'(m_valid));
    check_val("key_held", 32'(key_held), 32'(m_locked));
    check_val("key_code", 32'(key_code), 32'(m_code));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic bounce_burst(input int n);
    repeat (n) begin
      bounce_open = 1'b1; run($urandom_range(1, 6));
      bounce_open = 1'b0; run($urandom_range(1, 6));
    end
  endtask

  // Asynchronous assert mid-cycle, release on a falling edge.
  task automatic do_reset(input int n);
    #2 reset = 1'b0;
    #1;
    check_val("rst_col", 32'(col), 32'(4'b1110));
    check_val("rst_code", 32'(key_code), 32'(4'h0));
    check_val("rst_valid", 32'(key_valid), 32'(1'b0));
    check_val("rst_held", 32'(key_held), 32'(1'b0));
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_val("post_rst_col", 32'(col), 32'(4'b1110));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; pulse_cnt = 0;
    pressed = 16'h0000; bounce_open = 1'b0;
    row = 4'hF; reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("init_col", 32'(col), 32'(4'b1110));
    check_val("init_code", 32'(key_code), 32'(4'h0));
    check_val("init_valid", 32'(key_valid), 32'(1'b0));
    check_val("init_held", 32'(key_held), 32'(1'b0));
    reset = 1'b1;

    // Idle: columns rotate, no pulses.
    pulse_cnt = 0;
    run(40);
    check_val("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Key "6" held then released.
    pulse_cnt = 0;
    pressed = 16'h0000; pressed[1*4+2] = 1'b1;
    run(40);
    check_val("six_pulses", 32'(pulse_cnt), 32'd1);
    check_val("six_code", 32'(key_code), 32'h6);
    check_val("six_held", 32'(key_held), 32'd1);
    pressed = 16'h0000;
    for (int i = 0; i < 60 && m_locked; i++) step();
    check_val("six_released", 32'(key_held), 32'd0);
    check_val("six_resume_col", 32'(col), 32'(4'b0111));

    // Press bounce on "1": first attempt discarded.
    do_reset(2);
    pulse_cnt = 0;
    pressed = 16'h0001;
    bounce_open = 1'b0; run(4);
    bounce_open = 1'b1; run(4);
    bounce_open = 1'b0; run(80);
    check_val("bnc_pulses", 32'(pulse_cnt), 32'd1);
    check_val("bnc_code", 32'(key_code), 32'h1);
    pressed = 16'h0000; run(30);

    // Release bounce on "D": high 2 ticks, low 1, high 3.
    do_reset(2);
    pulse_cnt = 0;
    pressed = 16'h8000;
    run(60);
    check_val("d_code", 32'(key_code), 32'hD);
    pressed = 16'h0000; run(8);
    pressed = 16'h8000; run(4);
    pressed = 16'h0000; run(8);
    check_val("d_still_held", 32'(key_held), 32'd1);
    run(4);
    check_val("d_dropped", 32'(key_held), 32'd0);
    check_val("d_pulses", 32'(pulse_cnt), 32'd1);
    run(20);

    // Rows 1 and 3 at col0 resolve to "4"; "A" during hold is ignored.
    do_reset(2);
    pulse_cnt = 0;
    pressed = 16'h0000; pressed[1*4+0] = 1'b1; pressed[3*4+0] = 1'b1;
    run(40);
    check_val("multi_code", 32'(key_code), 32'h4);
    pressed[0*4+3] = 1'b1;
    run(40);
    check_val("multi_pulses", 32'(pulse_cnt), 32'd1);
    check_val("multi_code_kept", 32'(key_code), 32'h4);
    pressed = 16'h0000; run(40);

    // Reset during debounce aborts without a pulse.
    do_reset(2);
    pulse_cnt = 0;
    pressed = 16'h0000; pressed[1*4+1] = 1'b1;
    for (int i = 0; i < 40 && !(m_streak > 0 && !m_locked); i++) step();
    check_val("dbg_reached", 32'(m_streak > 0), 32'd1);
    pressed = 16'h0000;
    do_reset(3);
    run(30);
    check_val("dbg_rst_pulses", 32'(pulse_cnt), 32'd0);

    // Randomized presses with bounce on press and release.
    for (int it = 0; it < 30; it++) begin
      int k;
      k = $urandom_range(0, 15);
      pressed = 16'h0000;
      pressed[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 15);
        pressed[k] = 1'b1;
      end
      bounce_burst($urandom_range(0, 4));
      run($urandom_range(30, 70));
      if ($urandom_range(0, 7) == 0) do_reset($urandom_range(1, 3));
      bounce_burst($urandom_range(0, 4));
      pressed = 16'h0000;
      run($urandom_range(20, 45));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
